// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS pipeline: the ID/EX register (which can be flushed),
// the forwarding muxes, the ALU operand B and destination muxes, and the ALU.
module execute_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        FlushE,
  input  logic        RegWriteD,
  input  logic        MemtoRegD,
  input  logic        MemWriteD,
  input  logic [3:0]  ALUControlD,
  input  logic        ALUSrcD,
  input  logic        RegDstD,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RdD,
  input  logic [31:0] SignImmD,
  output logic        RegWriteE,
  output logic        MemtoRegE,
  output logic        MemWriteE,
  output logic        RegDstE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [4:0]  RsE,
  output logic [4:0]  RtE,
  output logic [4:0]  RdE,
  output logic [31:0] SignImmE,
  input  logic [31:0] ResultW,
  input  logic [31:0] ALUOutM,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  output logic [4:0]  WriteRegE,
  output logic [31:0] WriteDataE,
  output logic [31:0] ALUOutE
);

  logic [3:0]  aluControlE;
  logic        aluSrcE;
  logic [31:0] srcAE;
  logic [31:0] srcBE;

  // ID/EX pipeline register; a flush loads an all-zero bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWriteE   <= 1'b0;
      MemtoRegE   <= 1'b0;
      MemWriteE   <= 1'b0;
      aluControlE <= 4'd0;
      aluSrcE     <= 1'b0;
      RegDstE     <= 1'b0;
      RD1E        <= 32'd0;
      RD2E        <= 32'd0;
      RsE         <= 5'd0;
      RtE         <= 5'd0;
      RdE         <= 5'd0;
      SignImmE    <= 32'd0;
    end else if (FlushE) begin
      RegWriteE   <= 1'b0;
      MemtoRegE   <= 1'b0;
      MemWriteE   <= 1'b0;
      aluControlE <= 4'd0;
      aluSrcE     <= 1'b0;
      RegDstE     <= 1'b0;
      RD1E        <= 32'd0;
      RD2E        <= 32'd0;
      RsE         <= 5'd0;
      RtE         <= 5'd0;
      RdE         <= 5'd0;
      SignImmE    <= 32'd0;
    end else begin
      RegWriteE   <= RegWriteD;
      MemtoRegE   <= MemtoRegD;
      MemWriteE   <= MemWriteD;
      aluControlE <= ALUControlD;
      aluSrcE     <= ALUSrcD;
      RegDstE     <= RegDstD;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      RsE         <= RsD;
      RtE         <= RtD;
      RdE         <= RdD;
      SignImmE    <= SignImmD;
    end
  end

  assign WriteRegE = RegDstE ? RdE : RtE;

  always_comb begin
    srcAE = 32'd0;
    case (ForwardAE)
      2'd0:    srcAE = RD1E;
      2'd1:    srcAE = ResultW;
      2'd2:    srcAE = ALUOutM;
      default: srcAE = 32'd0;
    endcase
  end

  always_comb begin
    WriteDataE = 32'd0;
    case (ForwardBE)
      2'd0:    WriteDataE = RD2E;
      2'd1:    WriteDataE = ResultW;
      2'd2:    WriteDataE = ALUOutM;
      default: WriteDataE = 32'd0;
    endcase
  end

  assign srcBE = aluSrcE ? SignImmE : WriteDataE;

  // Arithmetic wraps silently; SLT compares as two's-complement.
  always_comb begin
    ALUOutE = 32'd0;
    case (aluControlE)
      4'd0:    ALUOutE = srcAE & srcBE;
      4'd1:    ALUOutE = srcAE | srcBE;
      4'd2:    ALUOutE = srcAE + srcBE;
      4'd3:    ALUOutE = srcAE ^ srcBE;
      4'd4:    ALUOutE = srcAE & ~srcBE;
      4'd5:    ALUOutE = srcAE | ~srcBE;
      4'd6:    ALUOutE = srcAE - srcBE;
      4'd7:    ALUOutE = ($signed(srcAE) < $signed(srcBE)) ? 32'd1 : 32'd0;
      default: ALUOutE = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: hand-computed vectors for the ID/EX register,
// flush/reset behaviour, forwarding muxes and each ALU operation.
`timescale 1ns/1ps
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        FlushE;
  logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [3:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, SignImmD, ResultW, ALUOutM;
  logic [4:0]  RsD, RtD, RdD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        RegWriteE, MemtoRegE, MemWriteE, RegDstE;
  logic [31:0] RD1E, RD2E, SignImmE, WriteDataE, ALUOutE;
  logic [4:0]  RsE, RtE, RdE, WriteRegE;

  int checks = 0;
  int failures = 0;

  execute_stage dut (
    .clk(clk), .reset_n(reset_n), .FlushE(FlushE),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
    .RD1D(RD1D), .RD2D(RD2D), .RsD(RsD), .RtD(RtD), .RdD(RdD), .SignImmD(SignImmD),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .RegDstE(RegDstE),
    .RD1E(RD1E), .RD2E(RD2E), .RsE(RsE), .RtE(RtE), .RdE(RdE), .SignImmE(SignImmE),
    .ResultW(ResultW), .ALUOutM(ALUOutM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .WriteRegE(WriteRegE), .WriteDataE(WriteDataE), .ALUOutE(ALUOutE)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end else begin
      $display("ok   %s: 0x%08h", tag, observed);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; FlushE = 1'b0;
    RegWriteD = 1'b0; MemtoRegD = 1'b0; MemWriteD = 1'b0; ALUSrcD = 1'b0; RegDstD = 1'b0;
    ALUControlD = 4'd0; RD1D = 32'd0; RD2D = 32'd0; SignImmD = 32'd0;
    RsD = 5'd0; RtD = 5'd0; RdD = 5'd0;
    ResultW = 32'd0; ALUOutM = 32'd0; ForwardAE = 2'd0; ForwardBE = 2'd0;

    // Reset state
    #12;
    checkVal("rst_RegWriteE", {31'd0, RegWriteE}, 32'd0);
    checkVal("rst_WriteRegE", {27'd0, WriteRegE}, 32'd0);
    checkVal("rst_ALUOutE", ALUOutE, 32'd0);
    reset_n = 1'b1;

    // Destination mux and register capture
    RtD = 5'd12; RdD = 5'd16; RsD = 5'd7; RegDstD = 1'b0;
    RegWriteD = 1'b1; MemWriteD = 1'b1; MemtoRegD = 1'b1;
    tick();
    checkVal("dst_rt", {27'd0, WriteRegE}, 32'd12);
    checkVal("cap_RsE", {27'd0, RsE}, 32'd7);
    checkVal("cap_RegWriteE", {31'd0, RegWriteE}, 32'd1);
    checkVal("cap_MemtoRegE", {31'd0, MemtoRegE}, 32'd1);
    RegDstD = 1'b1;
    tick();
    checkVal("dst_rd", {27'd0, WriteRegE}, 32'd16);
    checkVal("cap_RdE", {27'd0, RdE}, 32'd16);

    // Flush bubble
    FlushE = 1'b1;
    tick();
    checkVal("flush_WriteRegE", {27'd0, WriteRegE}, 32'd0);
    checkVal("flush_RegWriteE", {31'd0, RegWriteE}, 32'd0);
    checkVal("flush_MemWriteE", {31'd0, MemWriteE}, 32'd0);
    FlushE = 1'b0;

    // Asynchronous reset mid-cycle
    RD1D = 32'h1234; SignImmD = 32'h55;
    tick();
    checkVal("pre_rst_RD1E", RD1E, 32'h1234);
    #2 reset_n = 1'b0;
    #1;
    checkVal("arst_RD1E", RD1E, 32'd0);
    checkVal("arst_SignImmE", SignImmE, 32'd0);
    checkVal("arst_WriteRegE", {27'd0, WriteRegE}, 32'd0);
    checkVal("arst_RegWriteE", {31'd0, RegWriteE}, 32'd0);
    tick();
    checkVal("rst_over_load", RD1E, 32'd0);
    reset_n = 1'b1;
    RegWriteD = 1'b0; MemWriteD = 1'b0; MemtoRegD = 1'b0; SignImmD = 32'd0;

    // Store-data forwarding, combinational select
    RD2D = 32'd3; ResultW = 32'd32; ALUOutM = 32'd22;
    tick();
    checkVal("fwdB_0", WriteDataE, 32'd3);
    ForwardBE = 2'd1; #1;
    checkVal("fwdB_1", WriteDataE, 32'd32);
    ForwardBE = 2'd2; #1;
    checkVal("fwdB_2", WriteDataE, 32'd22);
    ForwardBE = 2'd3; #1;
    checkVal("fwdB_3", WriteDataE, 32'd0);
    ForwardBE = 2'd0;

    // ALU logic/add
    RD1D = 32'd42; ALUControlD = 4'd0;
    tick();
    checkVal("alu_and", ALUOutE, 32'd2);
    ALUControlD = 4'd1; ForwardAE = 2'd1;
    tick();
    checkVal("alu_or_fwdA", ALUOutE, 32'd35);
    ALUControlD = 4'd2; ForwardAE = 2'd0; ForwardBE = 2'd1;
    tick();
    checkVal("alu_add_fwdB", ALUOutE, 32'd74);

    // ALU sub/slt with forwarding
    ALUControlD = 4'd6; ForwardAE = 2'd2; ForwardBE = 2'd1;
    tick();
    checkVal("alu_sub_wrap", ALUOutE, 32'hFFFFFFF6);
    ALUControlD = 4'd7; ALUSrcD = 1'b1; SignImmD = 32'd0;
    tick();
    checkVal("slt_22_0", ALUOutE, 32'd0);
    SignImmD = 32'hFFFFFFFF;
    tick();
    checkVal("slt_22_m1", ALUOutE, 32'd0);
    SignImmD = 32'd100;
    tick();
    checkVal("slt_22_100", ALUOutE, 32'd1);

    // Pipeline timing: control change only takes effect at the edge
    ALUControlD = 4'd2; #2;
    checkVal("hold_before_edge", ALUOutE, 32'd1);
    tick();
    checkVal("add_imm", ALUOutE, 32'd122);

    // Remaining operations, A=22 (forwarded), B=100 (immediate)
    ALUControlD = 4'd3;
    tick();
    checkVal("alu_xor", ALUOutE, 32'd114);
    ALUControlD = 4'd4;
    tick();
    checkVal("alu_andn", ALUOutE, 32'd18);
    ALUControlD = 4'd5;
    tick();
    checkVal("alu_orn", ALUOutE, 32'hFFFFFF9F);
    ALUControlD = 4'd8;
    tick();
    checkVal("alu_op8", ALUOutE, 32'd0);
    ALUControlD = 4'd2; ForwardAE = 2'd3;
    tick();
    checkVal("fwdA_3_add", ALUOutE, 32'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
